clock_ctrl: RTL and testbench
=============================

# clock_ctrl

Upstream clock/step controller for the `cpu` top level. It derives the CPU's `clk`/`iclk` pair from one master clock and provides run, stop and single-step control. It consumes the CPU's `brk`/`hlt` outputs to pause or terminate execution at cycle boundaries. It also drives `ctrlen` and counts executed CPU cycles for the emulator front-end.

## Interface
Parameters:
- `DIV`, 4: master cycles per CPU clock phase (high and low phase each last `DIV`); legal range 1..255.
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `clk`  input  1  master clock; the only clock in the block.
- `rst`  input  1  reset, asynchronous, active-high.
- `run_req`  input  1  one-master-cycle pulse: enter free-run.
- `stop_req`  input  1  pulse: stop at the next cycle boundary.
- `step_req`  input  1  pulse: execute exactly one CPU cycle.
- `brk_en`  input  1  level: honour `brk` from the CPU.
- `brk`  input  1  CPU breakpoint request (control-word field).
- `hlt`  input  1  CPU halt request (control-word field).
- `cpu_clk`  output  1  drives CPU `clk`; registered.
- `cpu_iclk`  output  1  drives CPU `iclk`; registered, always `~cpu_clk`.
- `ctrlen`  output  1  control-word drive enable to the CPU.
- `running`  output  1  high in RUN or STEP.
- `halted`  output  1  high in HALTED.
- `cycles`  output  `CNT_W`  count of CPU rising edges since reset; saturating.

## Operation
- States: IDLE, RUN, STEP, HALTED. A 2-bit phase flag (HI/LO) and an 8-bit phase counter (0..DIV-1) track progress within each CPU cycle.
- IDLE:
  - `cpu_clk`=0 and the phase counter is held at 0.
  - `run_req` → RUN.
  - Else `step_req` → STEP. If both arrive together, run wins.
  - `stop_req` is ignored.
- RUN and STEP each produce full cycles: HI phase for `DIV` master cycles, then LO phase for `DIV` master cycles.
- Cycle boundary:
  - Defined as the master edge on which the LO phase counter = `DIV-1`.
  - Decisions are taken only there, using `hlt`, `brk`, `brk_en` and the latched stop flag sampled on that edge.
  - Priority at the boundary:
    1. `hlt`=1 → HALTED.
    2. Else `brk & brk_en` → IDLE.
    3. Else stop flag set → IDLE.
    4. Else STEP → IDLE.
    5. Else RUN continues with the next HI phase.
- `stop_req` during RUN/STEP sets a sticky stop flag. The flag clears on entry to IDLE.
- `run_req`/`step_req` during RUN/STEP are ignored.
- HALTED:
  - `cpu_clk`=0 and `ctrlen`=0, releasing the control bus.
  - All requests are ignored. Only `rst` exits.
- `ctrlen`=1 in IDLE, RUN and STEP; 0 in HALTED and during reset.
- `cycles` increments by 1 on every master edge where `cpu_clk` goes 0→1. It saturates at all-ones; it does not wrap.

## Timing
- Reset values:
  - state=IDLE, `cpu_clk`=0, `cpu_iclk`=1.
  - `ctrlen`=0, then 1 on the first master edge after `rst` falls.
  - `running`=0, `halted`=0, `cycles`=0, stop flag=0.
- Start latency: request sampled on master edge n → `cpu_clk` rises on edge n+1. `cycles` updates on the same edge as the rise.
- CPU clock period = 2·`DIV` master cycles, 50% duty. With `DIV`=1, `cpu_clk` toggles every master cycle.
- Stop/break latency: the last `cpu_clk` falling edge completes the current cycle; no partial HI phase is ever emitted. `cpu_clk` is 0 in the IDLE state entered on the boundary edge.
- STEP produces exactly one rising and one falling edge, then returns to IDLE. `running` is high for exactly 2·`DIV` master cycles.
- `rst` asserted mid-phase forces all outputs to reset values immediately (asynchronous). A truncated HI pulse on `cpu_clk` is acceptable only in this case.
- `brk`/`hlt` asserted outside the boundary edge have no effect unless still asserted at the boundary.

## Structure
- Shared package `clock_ctrl_pkg`:
  - state enum `cc_state_t` {IDLE, RUN, STEP, HALTED}.
  - phase enum {HI, LO}.
  - `DIV` range constants.
- Single module. An optional sub-module `phase_timer` holds the phase counter and HI/LO flag and outputs a `boundary` strobe. The FSM stays in `clock_ctrl`.

## Test plan
- Reset, then `step_req` pulse, `DIV`=4 → one `cpu_clk` pulse 4 master cycles high, 4 low; `cycles`=1; back in IDLE with `running`=0.
- `run_req`, let 10 cycles elapse, then `stop_req` mid-HI → the current cycle completes; `cycles`=11; IDLE; `cpu_clk`=0.
- RUN with `brk`=1 held in the LO phase of cycle 5:
  - with `brk_en`=1 → IDLE after 5 cycles.
  - with `brk_en`=0 → run continues.
- `hlt` and `brk` both asserted at a boundary → HALTED, `ctrlen`=0, `halted`=1. Subsequent `run_req`/`step_req` give no `cpu_clk` edges.
- `run_req` and `step_req` on the same master edge in IDLE → RUN (free-running beyond 2 cycles). `rst` pulse mid-HI → `cpu_clk`=0 and `cycles`=0 immediately.
- Preload `cycles` to all-ones−1 (force), run 3 cycles → `cycles` stays all-ones; `DIV`=1 → `cpu_clk` toggles every master edge.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the CPU clock/step controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } cc_state_t;

    typedef enum logic [1:0] {
        HI = 2'b01,
        LO = 2'b10
    } phase_t;

    localparam int DIV_MIN = 1;
    localparam int DIV_MAX = 255;

endpackage

// File: rtl/clock_ctrl_phase_timer.sv
// Phase timer: counts DIV master cycles per HI/LO phase and flags the
// last master edge of the LO phase as the CPU cycle boundary.
module phase_timer
    import clock_ctrl_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   active,
    output phase_t phase,
    output logic   boundary
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] count;

    // Held at the start of a HI phase whenever no cycle is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= HI;
            count <= 8'd0;
        end else if (!active) begin
            phase <= HI;
            count <= 8'd0;
        end else if (count == LAST) begin
            phase <= (phase == HI) ? LO : HI;
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign boundary = active && (phase == LO) && (count == LAST);

endmodule

// File: rtl/clock_ctrl.sv
// Derives the CPU clk/iclk pair from the master clock and provides run,
// stop and single-step control with brk/hlt handling at cycle boundaries.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             brk_en,
    input  logic             brk,
    input  logic             hlt,
    output logic             cpu_clk,
    output logic             cpu_iclk,
    output logic             ctrlen,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycles
);

    if (DIV < DIV_MIN || DIV > DIV_MAX) begin : g_bad_div
        $error("clock_ctrl: DIV out of range");
    end

    cc_state_t state;
    cc_state_t state_next;
    phase_t    phase;
    logic      boundary;
    logic      active;
    logic      stop_flag;
    logic      cpu_clk_next;

    assign active = (state == RUN) || (state == STEP);

    phase_timer #(.DIV(DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .phase    (phase),
        .boundary (boundary)
    );

    // Leaving RUN/STEP is only ever decided on the boundary edge, so a
    // started cycle always completes its LO phase.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_req)
                    state_next = RUN;
                else if (step_req)
                    state_next = STEP;
            end
            RUN, STEP: begin
                if (boundary) begin
                    if (hlt)
                        state_next = HALTED;
                    else if (brk && brk_en)
                        state_next = IDLE;
                    else if (stop_flag)
                        state_next = IDLE;
                    else if (state == STEP)
                        state_next = IDLE;
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    assign cpu_clk_next = active && (phase == HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cpu_clk   <= 1'b0;
            cpu_iclk  <= 1'b1;
            ctrlen    <= 1'b0;
            stop_flag <= 1'b0;
            cycles    <= '0;
        end else begin
            state    <= state_next;
            cpu_clk  <= cpu_clk_next;
            cpu_iclk <= ~cpu_clk_next;
            ctrlen   <= (state_next != HALTED);
            if (state_next == IDLE)
                stop_flag <= 1'b0;
            else if (active && stop_req)
                stop_flag <= 1'b1;
            if (cpu_clk_next && !cpu_clk && (cycles != '1))
                cycles <= cycles + 1'b1;
        end
    end

    assign running = active;
    assign halted  = (state == HALTED);

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: DIV=4 instance for control behaviour and a
// DIV=1, 4-bit counter instance for fast toggling and saturation.
module tb_clock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_req = 1'b0, stop_req = 1'b0, step_req = 1'b0;
    logic brk_en = 1'b0, brk = 1'b0, hlt = 1'b0;
    logic cpu_clk, cpu_iclk, ctrlen, running, halted;
    logic [31:0] cycles;

    logic run_b = 1'b0;
    logic tie0 = 1'b0;
    logic cpu_clk_b, cpu_iclk_b, ctrlen_b, running_b, halted_b;
    logic [3:0] cycles_b;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   vec_count  = 0;
    int   miss_count = 0;
    int   hi_len     = 0;
    int   bad_pulse  = 0;

    always #5 clk = ~clk;

    clock_ctrl #(.DIV(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .stop_req(stop_req),
        .step_req(step_req), .brk_en(brk_en), .brk(brk), .hlt(hlt),
        .cpu_clk(cpu_clk), .cpu_iclk(cpu_iclk), .ctrlen(ctrlen),
        .running(running), .halted(halted), .cycles(cycles)
    );

    clock_ctrl #(.DIV(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .run_req(run_b), .stop_req(tie0),
        .step_req(tie0), .brk_en(tie0), .brk(tie0), .hlt(tie0),
        .cpu_clk(cpu_clk_b), .cpu_iclk(cpu_iclk_b), .ctrlen(ctrlen_b),
        .running(running_b), .halted(halted_b), .cycles(cycles_b)
    );

    // Any completed HI pulse on the DIV=4 instance must be exactly 4 long.
    always @(negedge clk) begin
        if (rst) begin
            hi_len = 0;
        end else if (cpu_clk) begin
            hi_len = hi_len + 1;
        end else begin
            if (hi_len != 0 && hi_len != 4)
                bad_pulse = bad_pulse + 1;
            hi_len = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vec_count = vec_count + 1;
        if (observed !== expected) begin
            miss_count = miss_count + 1;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] observed);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", observed, ~observed);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    task automatic wait_k(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 0 run, 1 stop, 2 step, 3 run+step, 4 run on the DIV=1 instance.
    task automatic applyStimulus(input int which);
        @(negedge clk);
        case (which)
            0: run_req = 1'b1;
            1: stop_req = 1'b1;
            2: step_req = 1'b1;
            3: begin run_req = 1'b1; step_req = 1'b1; end
            default: run_b = 1'b1;
        endcase
        @(negedge clk);
        run_req  = 1'b0;
        stop_req = 1'b0;
        step_req = 1'b0;
        run_b    = 1'b0;
    endtask

    task automatic sample_pattern(input int n, output logic [63:0] clk_pat,
                                  output logic [63:0] run_pat);
        clk_pat = '0;
        run_pat = '0;
        for (int k = 0; k < n; k++) begin
            clk_pat[k] = cpu_clk;
            run_pat[k] = running;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_k(2);
        push_exp("rst_outputs", 64'h10);
        pop_check({58'd0, cpu_clk, cpu_iclk, ctrlen, running, halted, 1'b0});
        push_exp("rst_cycles", 64'd0);
        pop_check({32'd0, cycles});
        rst = 1'b0;
        @(negedge clk);
        push_exp("ctrlen_after_rst", 64'd1);
        pop_check({63'd0, ctrlen});
    endtask

    logic [63:0] clk_pat, run_pat;

    initial begin
        // Single step: 4 high, 4 low, running for 8 master cycles.
        do_reset();
        push_exp("step_clk_pattern", 64'h01E);
        push_exp("step_run_pattern", 64'h0FF);
        push_exp("step_cycles", 64'd1);
        applyStimulus(2);
        sample_pattern(12, clk_pat, run_pat);
        pop_check(clk_pat);
        pop_check(run_pat);
        pop_check({32'd0, cycles});

        // Free run, stop mid-HI of cycle 11; the cycle completes.
        do_reset();
        push_exp("stop_cycles", 64'd11);
        push_exp("stop_idle", 64'd0);
        push_exp("stop_no_short_pulse", 64'd0);
        applyStimulus(0);
        wait_k(82);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        wait_k(12);
        pop_check({32'd0, cycles});
        pop_check({62'd0, running, cpu_clk});
        pop_check(64'(bad_pulse));
        applyStimulus(1);
        wait_k(4);
        push_exp("stop_in_idle_ignored", 64'd11);
        pop_check({32'd0, cycles});

        // brk in LO of cycle 5 with brk_en=1 (plus a brk glitch mid-HI).
        do_reset();
        brk_en = 1'b1;
        push_exp("brk_en_cycles", 64'd5);
        push_exp("brk_en_idle", 64'd0);
        applyStimulus(0);
        wait_k(10);
        brk = 1'b1;
        wait_k(2);
        brk = 1'b0;
        wait_k(25);
        brk = 1'b1;
        wait_k(4);
        brk = 1'b0;
        wait_k(4);
        pop_check({32'd0, cycles});
        pop_check({63'd0, running});

        // Same sequence with brk_en=0: run continues.
        do_reset();
        brk_en = 1'b0;
        push_exp("brk_dis_running", 64'd1);
        push_exp("brk_dis_cycles", 64'd6);
        applyStimulus(0);
        wait_k(37);
        brk = 1'b1;
        wait_k(4);
        brk = 1'b0;
        wait_k(4);
        pop_check({63'd0, running});
        pop_check({32'd0, cycles});

        // hlt and brk together at a boundary: HALTED wins.
        do_reset();
        brk_en = 1'b1;
        push_exp("halt_status", 64'b100);
        push_exp("halt_cycles", 64'd1);
        push_exp("halt_no_edges", 64'd0);
        push_exp("halt_still_halted", 64'b100);
        applyStimulus(0);
        wait_k(5);
        hlt = 1'b1;
        brk = 1'b1;
        wait_k(5);
        hlt = 1'b0;
        brk = 1'b0;
        brk_en = 1'b0;
        pop_check({61'd0, halted, ctrlen, running});
        pop_check({32'd0, cycles});
        applyStimulus(0);
        applyStimulus(2);
        sample_pattern(20, clk_pat, run_pat);
        pop_check(clk_pat);
        pop_check({61'd0, halted, ctrlen, running});

        // run+step together: free run; then rst mid-HI clears immediately.
        do_reset();
        push_exp("both_req_running", 64'd1);
        push_exp("both_req_cycles", 64'd4);
        push_exp("async_rst_outputs", 64'b01000);
        push_exp("async_rst_cycles", 64'd0);
        applyStimulus(3);
        wait_k(26);
        pop_check({63'd0, running});
        pop_check({32'd0, cycles});
        #2 rst = 1'b1;
        #1;
        pop_check({59'd0, cpu_clk, cpu_iclk, ctrlen, running, halted});
        pop_check({32'd0, cycles});

        // DIV=1 instance: toggle every edge, 4-bit counter saturates.
        do_reset();
        push_exp("div1_toggle", 64'hAAA);
        push_exp("sat_before", 64'd14);
        push_exp("sat_hold", 64'd15);
        applyStimulus(4);
        clk_pat = '0;
        for (int k = 0; k < 12; k++) begin
            clk_pat[k] = cpu_clk_b;
            @(negedge clk);
        end
        pop_check(clk_pat);
        wait_k(15);
        pop_check({60'd0, cycles_b});
        wait_k(13);
        pop_check({60'd0, cycles_b});

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
